ll_walker: RTL

//  Read-side client of the linked-list node memory. From a head address, it follows next-pointers

---
 rtl/ll_walker_if.sv | 25 ++
 rtl/ll_walker.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ll_walker_if.sv
// rtl/ll_walker_if.sv - node output stream and memory read port of the linked-list walker
interface ll_walker_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int VAL_WIDTH  = DATA_WIDTH - 1 - ADDR_WIDTH
);
  logic                  out_valid;
  logic                  out_ready;
  logic [VAL_WIDTH-1:0]  out_value;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // master: the walker; slave: the node consumer together with the node memory
  modport master (
    output out_valid, out_value, out_addr, mem_rd_en, mem_rd_addr,
    input  out_ready, mem_rd_data
  );

  modport slave (
    input  out_valid, out_value, out_addr, mem_rd_en, mem_rd_addr,
    output out_ready, mem_rd_data
  );
endinterface

// File: rtl/ll_walker.sv
// rtl/ll_walker.sv - follows next-pointers from a head node and streams each node value
module ll_walker #(
  parameter int MEM_DEPTH    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int DELAY_CYCLES = 3,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH),
  localparam int VAL_WIDTH   = DATA_WIDTH - 1 - ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] head_addr,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   node_count,
  ll_walker_if.master           bus
);
  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_q;
  logic                  last_q;
  logic [CNT_W-1:0]      cnt;
  logic                  out_valid_q;
  logic [VAL_WIDTH-1:0]  out_value_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_value   = out_value_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      next_q      <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      node_count  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        busy        <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cur_addr   <= head_addr;
              node_count <= '0;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= head_addr;
              busy       <= 1'b1;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            cnt   <= CNT_W'(DELAY_CYCLES - 1);
            state <= WAIT;
          end
          WAIT: begin
            // Capture is timed from our own ISSUE, so data from an aborted walk is never taken
            if (cnt == '0) begin
              last_q      <= bus.mem_rd_data[DATA_WIDTH-1];
              next_q      <= bus.mem_rd_data[DATA_WIDTH-2 -: ADDR_WIDTH];
              out_value_q <= bus.mem_rd_data[VAL_WIDTH-1:0];
              out_addr_q  <= cur_addr;
              out_valid_q <= 1'b1;
              state       <= EMIT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          EMIT: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              node_count  <= node_count + 1'b1;
              if (last_q) begin
                done  <= 1'b1;
                state <= FIN;
              end else if (node_count == (ADDR_WIDTH+1)'(MEM_DEPTH - 1)) begin
                done  <= 1'b1;
                err   <= 1'b1;
                state <= FIN;
              end else begin
                cur_addr  <= next_q;
                rd_en_q   <= 1'b1;
                rd_addr_q <= next_q;
                state     <= ISSUE;
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
